seven_seg_capture: RTL and testbench

//  Reverse of the hex-to-segment path: samples a time-multiplexed 7-seg display bus
//  (segments + one-hot digit enables) and recovers the hex value being shown.

---
 rtl/seven_seg_pkg.sv | 76 +++++++
 rtl/seven_seg_decode.sv | 15 +
 rtl/seven_seg_capture.sv | 146 ++++++++++++++
 tb/tb_seven_seg_capture.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared 7-segment constants (bit0=a .. bit6=g, active-high) and
// nibble<->segment lookups used by the capture path and the hex driver.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } out_state_e;

    function automatic logic [6:0] nib2seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = SEG_A;
            4'hB: s = SEG_B;
            4'hC: s = SEG_C;
            4'hD: s = SEG_D;
            4'hE: s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

    // Returns {valid, nibble}; undecodable patterns give nibble 0.
    function automatic logic [4:0] seg2nib(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            SEG_0: r = 5'h10;
            SEG_1: r = 5'h11;
            SEG_2: r = 5'h12;
            SEG_3: r = 5'h13;
            SEG_4: r = 5'h14;
            SEG_5: r = 5'h15;
            SEG_6: r = 5'h16;
            SEG_7: r = 5'h17;
            SEG_8: r = 5'h18;
            SEG_9: r = 5'h19;
            SEG_A: r = 5'h1A;
            SEG_B: r = 5'h1B;
            SEG_C: r = 5'h1C;
            SEG_D: r = 5'h1D;
            SEG_E: r = 5'h1E;
            SEG_F: r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational segment-pattern decoder.
// Ports: seg[6:0] in (a..g); valid out (pattern is a hex glyph); nibble[3:0] out.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] nibble
);

    always_comb begin
        {valid, nibble} = seg2nib(seg);
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Recovers the hex frame from a multiplexed 7-seg bus: debounce, decode, assemble.
// Ports: clk, rst_n, seg_in[6:0], dig_sel[N-1:0] in; value_out[4N-1:0], out_valid,
//  frame_err, overflow out; out_ready in. SEVEN_SEG_CAPTURE_ERR_EN keeps bad glyphs.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] value_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    frame_err,
    output logic                    overflow
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_HIT = CW'(STABLE_CYCLES - 2);

    logic [NUM_DIGITS+6:0]   samp_q;
    logic [CW-1:0]           cnt_q;
    logic                    same;
    logic                    accept;
    logic                    take;
    logic                    dec_valid;
    logic [3:0]              dec_nib;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] slot_q, slot_d;
    logic                    frame;
    logic                    load;
    logic                    drop;
    out_state_e              state_q;

    assign same  = ({dig_sel, seg_in} == samp_q);
    assign frame = &seen_q;
    // Fires on the edge where the count moves to its saturation value.
    assign accept = same && (cnt_q == CNT_HIT) && $onehot(dig_sel);

    seven_seg_decode u_dec (
        .seg    (seg_in),
        .valid  (dec_valid),
        .nibble (dec_nib)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q <= '0;
            cnt_q  <= '0;
        end else begin
            samp_q <= {dig_sel, seg_in};
            if (!same)
                cnt_q <= '0;
            else if (cnt_q != CNT_MAX)
                cnt_q <= cnt_q + 1'b1;
        end
    end

`ifdef SEVEN_SEG_CAPTURE_ERR_EN
    logic [NUM_DIGITS-1:0] err_q, err_d;

    assign take = accept;
`else
    assign take = accept && dec_valid;
`endif

    always_comb begin
        seen_d = frame ? '0 : seen_q;
        slot_d = slot_q;
`ifdef SEVEN_SEG_CAPTURE_ERR_EN
        err_d  = err_q;
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (take && dig_sel[i]) begin
                seen_d[i]       = 1'b1;
                slot_d[4*i +: 4] = dec_nib;
`ifdef SEVEN_SEG_CAPTURE_ERR_EN
                err_d[i]        = !dec_valid;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= '0;
            slot_q <= '0;
`ifdef SEVEN_SEG_CAPTURE_ERR_EN
            err_q  <= '0;
`endif
        end else begin
            seen_q <= seen_d;
            slot_q <= slot_d;
`ifdef SEVEN_SEG_CAPTURE_ERR_EN
            err_q  <= err_d;
`endif
        end
    end

    assign load = frame && ((state_q == ST_EMPTY) || out_ready);
    assign drop = frame && (state_q == ST_FULL) && !out_ready;

`ifndef SEVEN_SEG_CAPTURE_ERR_EN
    assign frame_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            out_valid <= 1'b0;
            value_out <= '0;
            overflow  <= 1'b0;
`ifdef SEVEN_SEG_CAPTURE_ERR_EN
            frame_err <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (frame) begin
                        state_q   <= ST_FULL;
                        out_valid <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (out_ready && !frame) begin
                        state_q   <= ST_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
            endcase
            if (load) begin
                value_out <= slot_q;
`ifdef SEVEN_SEG_CAPTURE_ERR_EN
                frame_err <= |err_q;
`endif
            end
            if (drop)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench for seven_seg_capture (NUM_DIGITS=2, STABLE_CYCLES=4).
// Directed frames push expected words; a negedge monitor pops on handshakes.
module tb_seven_seg_capture;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg_in;
    logic [1:0] dig_sel;
    logic [7:0] value_out;
    logic       out_valid;
    logic       out_ready;
    logic       frame_err;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    logic [8:0] sb [$];

    logic [6:0] segtab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    seven_seg_capture #(
        .NUM_DIGITS    (2),
        .STABLE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .dig_sel   (dig_sel),
        .value_out (value_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [1:0] d, input logic [6:0] s,
                        input int n);
        dig_sel = d;
        seg_in  = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] v);
        hold(2'b00, 7'h00, 1);
        hold(2'b01, segtab[v[3:0]], 4);
        hold(2'b10, segtab[v[7:4]], 4);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted output word is checked against the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word actual=%0h required=none",
                         {frame_err, value_out});
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                if ({frame_err, value_out} !== e) begin
                    errors++;
                    $display("FAIL word actual=%0h required=%0h",
                             {frame_err, value_out}, e);
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        seg_in    = 7'h00;
        dig_sel   = 2'b00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_value", value_out, 8'h00);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_err", frame_err, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        rst_n = 1'b1;

        // 1: basic frame 35, latency and single-cycle valid
        out_ready = 1'b1;
        sb.push_back({1'b0, 8'h35});
        frame(8'h35);
        chk("t1_not_early", out_valid, 1'b0);
        step();
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_value", value_out, 8'h35);
        step();
        chk("t1_valid_drop", out_valid, 1'b0);

        // 2: glitch 06 x3 then 07 x4 on digit 0
        sb.push_back({1'b0, 8'h27});
        hold(2'b00, 7'h00, 1);
        hold(2'b01, 7'h06, 3);
        hold(2'b01, 7'h07, 4);
        hold(2'b10, 7'h5B, 4);
        repeat (3) step();

        // 3: stalled consumer, second frame dropped
        out_ready = 1'b0;
        sb.push_back({1'b0, 8'hA1});
        frame(8'hA1);
        step();
        chk("t3_valid", out_valid, 1'b1);
        frame(8'hC2);
        step();
        chk("t3_hold_value", value_out, 8'hA1);
        chk("t3_overflow", overflow, 1'b1);
        out_ready = 1'b1;
        step();
        chk("t3_drained", out_valid, 1'b0);

        // 4: back-to-back load while pending word is accepted
        out_ready = 1'b0;
        sb.push_back({1'b0, 8'h12});
        frame(8'h12);
        step();
        chk("t4_pending", value_out, 8'h12);
        sb.push_back({1'b0, 8'h34});
        frame(8'h34);
        out_ready = 1'b1;
        step();
        chk("t4_no_bubble", out_valid, 1'b1);
        chk("t4_value", value_out, 8'h34);
        step();
        chk("t4_drop", out_valid, 1'b0);

        // 5: blank pattern on digit 0
`ifdef SEVEN_SEG_CAPTURE_ERR_EN
        sb.push_back({1'b1, 8'h80});
        hold(2'b00, 7'h00, 1);
        hold(2'b01, 7'h00, 6);
        hold(2'b10, segtab[8], 4);
        step();
        chk("t5_err_valid", out_valid, 1'b1);
        chk("t5_err_flag", frame_err, 1'b1);
        repeat (2) step();
`else
        sb.push_back({1'b0, 8'h83});
        hold(2'b00, 7'h00, 1);
        hold(2'b01, 7'h00, 6);
        hold(2'b10, segtab[8], 4);
        hold(2'b00, 7'h00, 3);
        chk("t5_stalled", out_valid, 1'b0);
        hold(2'b01, segtab[3], 4);
        step();
        chk("t5_valid", out_valid, 1'b1);
        repeat (2) step();
`endif

        // 6: reset after a partial frame
        hold(2'b00, 7'h00, 1);
        hold(2'b10, segtab[7], 4);
        rst_n = 1'b0;
        repeat (2) step();
        chk("t6_ovf", overflow, 1'b0);
        chk("t6_valid", out_valid, 1'b0);
        chk("t6_value", value_out, 8'h00);
        rst_n = 1'b1;
        sb.push_back({1'b0, 8'h9E});
        frame(8'h9E);
        repeat (3) step();
        chk("t6_ovf_after", overflow, 1'b0);

        // 7: multi-hot dig_sel never accepts
        hold(2'b00, 7'h00, 1);
        hold(2'b11, 7'h06, 10);
        hold(2'b10, segtab[5], 4);
        hold(2'b00, 7'h00, 3);
        chk("t7_no_frame", out_valid, 1'b0);
        sb.push_back({1'b0, 8'h56});
        hold(2'b01, segtab[6], 4);
        step();
        chk("t7_valid", out_valid, 1'b1);

        for (int i = 0; i < 20 && sb.size() != 0; i++)
            step();
        chk("queue_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
